// File: rtl/datapath_cpu.sv
// Execution datapath slaved to the 8-bit CPU control sequencer.
// Each cycle it decodes the sequencer phase code and performs that phase's register transfer.
module datapath_cpu #(
  parameter int ADDR_W = 8,
  parameter int OUT_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        state,
  input  logic              allow_up,
  input  logic [7:0]        ram_data,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [3:0]        opcode,
  output logic [7:0]        acc,
  output logic              zero,
  output logic              carry,
  output logic              rom_we,
  output logic [OUT_W-1:0]  rom_addr,
  output logic [7:0]        rom_data
);

  localparam logic [3:0] ST_PC      = 4'd1;
  localparam logic [3:0] ST_RAM     = 4'd2;
  localparam logic [3:0] ST_IR      = 4'd3;
  localparam logic [3:0] ST_REG_IN  = 4'd5;
  localparam logic [3:0] ST_ALU     = 4'd6;
  localparam logic [3:0] ST_ALU_OUT = 4'd7;
  localparam logic [3:0] ST_REG_OUT = 4'd8;
  localparam logic [3:0] ST_ROM     = 4'd9;
  localparam logic [3:0] ST_JUMP    = 4'd10;

  logic [ADDR_W-1:0] pc_q, pc_d, ram_addr_q, ram_addr_d;
  logic [7:0]        mdr_q, mdr_d, ir_q, ir_d, op_a_q, op_a_d, op_b_q, op_b_d;
  logic [7:0]        acc_q, acc_d, rom_data_q, rom_data_d;
  logic [8:0]        res_q, res_d, alu_res;
  logic [3:0]        opcode_q, opcode_d;
  logic              zero_q, zero_d, carry_q, carry_d, rom_we_q, rom_we_d;
  logic [OUT_W-1:0]  rom_addr_q, rom_addr_d, out_ptr_q, out_ptr_d;

  // res[8] carries the carry/borrow; logic ops and NOP-class leave it clear
  always_comb begin
    alu_res = {1'b0, op_a_q};
    case (ir_q[7:4])
      4'h1:    alu_res = {1'b0, op_b_q};
      4'h2:    alu_res = {1'b0, op_a_q} + {1'b0, op_b_q};
      4'h3:    alu_res = {1'b0, op_a_q} - {1'b0, op_b_q};
      4'h4:    alu_res = {1'b0, op_a_q & op_b_q};
      4'h5:    alu_res = {1'b0, op_a_q | op_b_q};
      4'h6:    alu_res = {1'b0, op_a_q ^ op_b_q};
      4'h7:    alu_res = {1'b0, op_a_q} + 9'd1;
      4'h8:    alu_res = {1'b0, op_a_q} - 9'd1;
      4'h9:    alu_res = {op_a_q, 1'b0};
      4'hA:    alu_res = {op_a_q[0], 1'b0, op_a_q[7:1]};
      4'hB:    alu_res = {1'b0, ~op_a_q};
      default: alu_res = {1'b0, op_a_q};
    endcase
  end

  always_comb begin
    pc_d       = pc_q;
    ram_addr_d = ram_addr_q;
    mdr_d      = mdr_q;
    ir_d       = ir_q;
    opcode_d   = opcode_q;
    op_a_d     = op_a_q;
    op_b_d     = op_b_q;
    res_d      = res_q;
    acc_d      = acc_q;
    zero_d     = zero_q;
    carry_d    = carry_q;
    rom_addr_d = rom_addr_q;
    rom_data_d = rom_data_q;
    out_ptr_d  = out_ptr_q;
    rom_we_d   = 1'b0;
    case (state)
      ST_PC: begin
        ram_addr_d = pc_q;
        pc_d       = pc_q + ADDR_W'(1);
      end
      ST_RAM: mdr_d = ram_data;
      ST_IR: begin
        ir_d     = mdr_q;
        opcode_d = mdr_q[7:4];
      end
      ST_REG_IN: begin
        op_a_d = acc_q;
        op_b_d = {4'b0, ir_q[3:0]};
      end
      ST_ALU: res_d = alu_res;
      ST_ALU_OUT: begin
        zero_d  = (res_q[7:0] == 8'h00);
        carry_d = res_q[8];
      end
      ST_REG_OUT: begin
        if (allow_up) begin
          acc_d      = res_q[7:0];
          rom_data_d = res_q[7:0];
          rom_addr_d = out_ptr_q;
          rom_we_d   = 1'b1;
        end
      end
      ST_ROM: begin
        if (rom_we_q) out_ptr_d = out_ptr_q + OUT_W'(1);
      end
      // jump pre-loads the fetch address, so the sequencer skips the PC phase
      ST_JUMP: begin
        ram_addr_d = ADDR_W'(ir_q[3:0]);
        pc_d       = ADDR_W'(ir_q[3:0]) + ADDR_W'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q       <= '0;
      ram_addr_q <= '0;
      mdr_q      <= '0;
      ir_q       <= '0;
      opcode_q   <= '0;
      op_a_q     <= '0;
      op_b_q     <= '0;
      res_q      <= '0;
      acc_q      <= '0;
      zero_q     <= 1'b0;
      carry_q    <= 1'b0;
      rom_we_q   <= 1'b0;
      rom_addr_q <= '0;
      rom_data_q <= '0;
      out_ptr_q  <= '0;
    end else begin
      pc_q       <= pc_d;
      ram_addr_q <= ram_addr_d;
      mdr_q      <= mdr_d;
      ir_q       <= ir_d;
      opcode_q   <= opcode_d;
      op_a_q     <= op_a_d;
      op_b_q     <= op_b_d;
      res_q      <= res_d;
      acc_q      <= acc_d;
      zero_q     <= zero_d;
      carry_q    <= carry_d;
      rom_we_q   <= rom_we_d;
      rom_addr_q <= rom_addr_d;
      rom_data_q <= rom_data_d;
      out_ptr_q  <= out_ptr_d;
    end
  end

  assign ram_addr = ram_addr_q;
  assign opcode   = opcode_q;
  assign acc      = acc_q;
  assign zero     = zero_q;
  assign carry    = carry_q;
  assign rom_we   = rom_we_q;
  assign rom_addr = rom_addr_q;
  assign rom_data = rom_data_q;

endmodule

// File: tb/tb_datapath_cpu.sv
// Bench for datapath_cpu: drives legal sequencer phase sequences against an
// instruction-level model and compares every output on every falling edge.
module tb_datapath_cpu;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] state = 4'd0;
  logic       allow_up = 1'b0;
  logic [7:0] ram_data;
  logic [7:0] ram_addr;
  logic [3:0] opcode;
  logic [7:0] acc, rom_data;
  logic       zero, carry, rom_we;
  logic [3:0] rom_addr;

  logic [7:0] prog [256];

  datapath_cpu #(.ADDR_W(8), .OUT_W(4)) dut (
    .clk(clk), .rst(rst), .state(state), .allow_up(allow_up),
    .ram_data(ram_data), .ram_addr(ram_addr), .opcode(opcode), .acc(acc),
    .zero(zero), .carry(carry), .rom_we(rom_we), .rom_addr(rom_addr),
    .rom_data(rom_data)
  );

  assign ram_data = prog[ram_addr];

  always #5 clk = ~clk;

  int errs = 0;
  int checks = 0;
  bit check_en = 1'b0;

  // expected outputs and hidden model state
  int exp_ram_addr = 0, exp_opcode = 0, exp_acc = 0, exp_zero = 0, exp_carry = 0;
  int exp_rom_we = 0, exp_rom_addr = 0, exp_rom_data = 0;
  int m_pc = 0, m_ptr = 0;
  bit after_jump = 1'b0;

  task automatic chk(input string nm, input int act, input int want);
    checks++;
    if (act != want) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, want, $time);
    end
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      chk("ram_addr", int'(ram_addr), exp_ram_addr);
      chk("opcode",   int'(opcode),   exp_opcode);
      chk("acc",      int'(acc),      exp_acc);
      chk("zero",     int'(zero),     exp_zero);
      chk("carry",    int'(carry),    exp_carry);
      chk("rom_we",   int'(rom_we),   exp_rom_we);
      chk("rom_addr", int'(rom_addr), exp_rom_addr);
      chk("rom_data", int'(rom_data), exp_rom_data);
    end
  end

  function automatic void model_alu(input int op, input int a, input int b,
                                    output int r, output int c);
    c = 0;
    case (op)
      1:  r = b;
      2:  begin r = (a + b) % 256; c = (a + b > 255); end
      3:  begin r = (a - b + 256) % 256; c = (a < b); end
      4:  r = a & b;
      5:  r = a | b;
      6:  r = a ^ b;
      7:  begin r = (a + 1) % 256; c = (a == 255); end
      8:  begin r = (a + 255) % 256; c = (a == 0); end
      9:  begin r = (a * 2) % 256; c = (a >= 128); end
      10: begin r = a / 2; c = a % 2; end
      11: r = 255 - a;
      default: r = a;
    endcase
  endfunction

  task automatic step(input int st);
    state = st[3:0];
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    exp_ram_addr = 0; exp_opcode = 0; exp_acc = 0; exp_zero = 0; exp_carry = 0;
    exp_rom_we = 0; exp_rom_addr = 0; exp_rom_data = 0;
    m_pc = 0; m_ptr = 0; after_jump = 1'b0;
  endtask

  // One full instruction as the sequencer would drive it; optional reset at ALU.
  task automatic run_instr(input bit allow, input bit rst_at_alu);
    int instr, a, b, r, c;
    if (!after_jump) begin
      step(1);
      exp_ram_addr = m_pc;
      m_pc = (m_pc + 1) % 256;
    end
    instr = int'(prog[exp_ram_addr]);
    step(2);
    step(3);
    exp_opcode = instr / 16;
    step(4);
    if (exp_opcode == 15) begin
      step(10);
      exp_ram_addr = instr % 16;
      m_pc = instr % 16 + 1;
      after_jump = 1'b1;
      return;
    end
    after_jump = 1'b0;
    a = exp_acc;
    b = instr % 16;
    step(5);
    if (rst_at_alu) begin
      rst = 1'b1;
      step(6);
      rst = 1'b0;
      model_reset();
      return;
    end
    step(6);
    model_alu(exp_opcode, a, b, r, c);
    step(7);
    exp_zero = (r == 0);
    exp_carry = c;
    allow_up = allow;
    step(8);
    allow_up = 1'b0;
    if (allow) begin
      exp_acc = r; exp_rom_data = r; exp_rom_addr = m_ptr; exp_rom_we = 1;
    end
    step(9);
    if (exp_rom_we == 1) m_ptr = (m_ptr + 1) % 16;
    exp_rom_we = 0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) prog[i] = 8'h00;
    prog[0] = 8'h15; prog[1] = 8'h23; prog[2] = 8'h12; prog[3] = 8'h33;
    prog[4] = 8'h70; prog[5] = 8'hFA; prog[10] = 8'h11; prog[11] = 8'h12;
    prog[12] = 8'h27;

    rst = 1'b1;
    state = 4'($urandom_range(0, 15));
    @(posedge clk); #1;
    check_en = 1'b1;
    state = 4'($urandom_range(0, 15));
    @(posedge clk); #1;
    rst = 1'b0;
    chk("reset_acc", int'(acc), 0);
    chk("reset_rom_we", int'(rom_we), 0);
    chk("reset_ram_addr", int'(ram_addr), 0);

    // LDI 5, ADD 3
    run_instr(1'b1, 1'b0);
    chk("ldi_acc", int'(acc), 5);
    chk("ldi_rom_addr", int'(rom_addr), 0);
    chk("ldi_rom_data", int'(rom_data), 5);
    run_instr(1'b1, 1'b0);
    chk("add_acc", int'(acc), 8);
    chk("add_zero", int'(zero), 0);
    chk("add_carry", int'(carry), 0);
    chk("add_rom_addr", int'(rom_addr), 1);
    chk("add_rom_data", int'(rom_data), 8);

    // LDI 2, SUB 3 -> borrow
    run_instr(1'b1, 1'b0);
    run_instr(1'b1, 1'b0);
    chk("sub_acc", int'(acc), 8'hFF);
    chk("sub_carry", int'(carry), 1);
    chk("sub_zero", int'(zero), 0);

    // INC 0xFF -> wrap to zero with carry
    run_instr(1'b1, 1'b0);
    chk("inc_acc", int'(acc), 0);
    chk("inc_zero", int'(zero), 1);
    chk("inc_carry", int'(carry), 1);

    // JUMP 0xA, then gated write-back, then fetch from 0x0B
    run_instr(1'b1, 1'b0);
    chk("jmp_opcode", int'(opcode), 15);
    chk("jmp_ram_addr", int'(ram_addr), 8'h0A);
    run_instr(1'b0, 1'b0);
    chk("gated_acc", int'(acc), 0);
    chk("gated_rom_addr", int'(rom_addr), 4);
    run_instr(1'b1, 1'b0);
    chk("after_jmp_ram_addr", int'(ram_addr), 8'h0B);
    chk("after_jmp_acc", int'(acc), 2);
    chk("after_jmp_rom_addr", int'(rom_addr), 5);

    // reset during ALU, then an unused state code held for 5 cycles
    run_instr(1'b1, 1'b1);
    chk("rst_alu_acc", int'(acc), 0);
    chk("rst_alu_opcode", int'(opcode), 0);
    chk("rst_alu_ram_addr", int'(ram_addr), 0);
    for (int i = 0; i < 5; i++) step(12);

    // 17 writing instructions: output pointer wraps
    for (int i = 0; i < 17; i++)
      prog[i] = 8'(($urandom_range(0, 11) << 4) | $urandom_range(0, 15));
    for (int i = 0; i < 17; i++) begin
      run_instr(1'b1, 1'b0);
      chk("wrap_rom_addr", int'(rom_addr), i % 16);
    end

    // random programs, random write-back gating
    for (int i = 0; i < 256; i++) prog[i] = 8'($urandom_range(0, 255));
    for (int i = 0; i < 300; i++)
      run_instr($urandom_range(0, 3) != 0, 1'b0);

    step(0);
    check_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
